nib_seq: RTL and testbench
==========================

# nib_seq

Programmable 4-bit value sequencer that sits directly upstream of the TriBuff classifier and drives its `en` and 4-bit `In` inputs. After a start pulse it walks a value between configurable low/high bounds with a configurable step and dwell time, in one-shot, wrap or bounce mode, and raises `en` only while a sequence is running. It exercises all three classifier bands (0–4, 5–9, 10–15) under deterministic, cycle-accurate control.

## Interface
- `DWELL_W`, default 4: width of the dwell count; each value is held `dwell+1` cycles.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset is synchronous and active-high.
- `start` input 1: level sampled each cycle; launches a sequence from IDLE.
- `stop` input 1: aborts a running sequence.
- `lo` input 4: lower bound, unsigned.
- `hi` input 4: upper bound, unsigned.
- `step` input 2: increment magnitude; 0 is treated as 1.
- `mode` input 2: 00 one-shot, 01 wrap, 10 bounce, 11 treated as one-shot.
- `dwell` input DWELL_W: extra hold cycles per value.
- `val` output 4: current value; connects to TriBuff `In`.
- `en` output 1: high while RUN; connects to TriBuff `en`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse when a one-shot sequence completes.
- `err` output 1: one-cycle pulse when `start` is rejected because `lo > hi`.

## Operation
- States: IDLE, RUN, DONE. Internal direction bit `up`, dwell counter `dcnt`, registered copies of `lo`, `hi`, `step`, `mode`, `dwell`.
- IDLE: `val`=0, `en`=0, `busy`=0.
  - `start`=1, `stop`=0, `lo<=hi`: capture the config, `val`<=`lo`, `up`<=1, `dcnt`<=`dwell`, go to RUN.
  - `start`=1, `lo>hi`: stay in IDLE and pulse `err` for one cycle.
  - `start` and `stop` both high: `stop` wins; nothing happens.
- RUN: `en`=1. If `dcnt`≠0, decrement it and hold `val`. If `dcnt`=0, advance `val` and reload `dcnt` from the captured `dwell`.
- Advance rules use 5-bit intermediates, and results are clamped so `val` never leaves [lo,hi]. `s` is the effective step (1–3).
  - One-shot: if `val==hi`, go to DONE. Otherwise `val`<=min(`val+s`, `hi`). `hi` is therefore always emitted.
  - Wrap: if `val==hi`, `val`<=`lo`. Otherwise `val`<=min(`val+s`, `hi`). Runs until `stop`.
  - Bounce, `up`=1: if `val==hi`, set `up`<=0 and `val`<=max(`val-s`, `lo`). Otherwise `val`<=min(`val+s`, `hi`).
  - Bounce, `up`=0: mirrored at `lo`. Runs until `stop`.
  - `lo==hi`: `val` stays at `lo`. One-shot finishes after one dwell period.
- `stop`=1 in RUN: next state IDLE, with `val`=0 and `en`=0 after that edge. No `done` pulse.
- DONE: lasts one cycle. `done`=1, `en`=0, `busy`=1, `val` holds `hi`. Then IDLE unconditionally. `start` during DONE is ignored.
- `start` during RUN is ignored. Changes to config inputs during RUN/DONE have no effect until the next accepted start.
- `rst`=1, including mid-sequence: at the next posedge the state is IDLE, all outputs are 0, `up`=1 and `dcnt`=0. Reset overrides `start` and `stop`.

## Timing
- Reset value of every output (`val`, `en`, `busy`, `done`, `err`): 0.
- `start` sampled at edge N means `en`=1 and `val`=`lo` are visible after edge N. This is one cycle of latency.
- Each value is held for exactly `dwell+1` cycles. With `dwell`=0, the value changes every cycle.
- One-shot total `en` high time: (number of distinct values emitted) × (`dwell+1`) cycles. DONE follows immediately, then IDLE one cycle later.
- `stop` sampled at edge M means `en`=0 after edge M.
- `err` rises after the edge that samples the rejected start and lasts exactly one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: hold `rst` 2 cycles mid-RUN (wrap mode) -> every output 0 after the first reset edge; `start` with `rst`=1 is ignored.
- One-shot basic: `lo`=3, `hi`=6, `step`=0, `dwell`=0, `mode`=00 -> `val` 3,4,5,6 with `en`=1 for 4 cycles; next cycle `done`=1, `en`=0, `val`=6; next cycle `val`=0, `busy`=0.
- Step clamp + dwell: `lo`=2, `hi`=11, `step`=3, `dwell`=1, one-shot -> `val` 2,2,5,5,8,8,11,11, then `done`; the sequence crosses all TriBuff bands.
- Wrap + stop: `lo`=8, `hi`=10, `step`=1, `mode`=01 -> 8,9,10,8,9,…; assert `stop` on a `val`=9 cycle -> `en`=0 and `val`=0 after that edge; no `done` pulse.
- Bounce: `lo`=0, `hi`=4, `step`=2, `mode`=10, `dwell`=0 -> 0,2,4,2,0,2,4,…
- Error/conflict: `lo`=7, `hi`=5 with `start` -> single `err` pulse, state stays IDLE; `start`+`stop` together in IDLE -> no activity; `start` during RUN -> no restart.

Source files
------------

// File: rtl/nib_seq.sv
// nib_seq: programmable 4-bit value sequencer feeding a TriBuff classifier.
// A start pulse launches a walk from lo to hi with a configurable step and
// a dwell of (dwell+1) cycles per value. Modes are one-shot, wrap and bounce.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_start, i_stop launch from IDLE / abort a running sequence
//   i_lo, i_hi      inclusive bounds (unsigned 4-bit)
//   i_step          step magnitude (0 acts as 1)
//   i_mode          00 one-shot, 01 wrap, 10 bounce, 11 one-shot
//   i_dwell         extra hold cycles per value
//   o_val, o_en     value and enable for the classifier
//   o_busy          high in RUN and DONE
//   o_done          one-cycle pulse when a one-shot completes
//   o_err           one-cycle pulse when a start is rejected (lo > hi)
module nib_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [3:0]         i_lo,
  input  logic [3:0]         i_hi,
  input  logic [1:0]         i_step,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [3:0]         o_val,
  output logic               o_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] M_ONE  = 2'b00;
  localparam logic [1:0] M_WRAP = 2'b01;
  localparam logic [1:0] M_BNC  = 2'b10;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_val, w_val_nxt;
  logic               r_up, w_up_nxt;
  logic [DWELL_W-1:0] r_dcnt, w_dcnt_nxt;
  logic               r_err, w_err_nxt;
  logic               w_cap;

  // Captured configuration; step and mode are stored already normalised.
  logic [3:0]         r_lo, r_hi;
  logic [1:0]         r_s, r_mode;
  logic [DWELL_W-1:0] r_dwell;

  // Advance candidates, computed with 5-bit intermediates and clamped
  // to the captured bounds so val can never leave [lo,hi].
  logic [4:0] w_inc;
  logic [3:0] w_inc_c, w_dec_c;
  logic       w_at_hi, w_at_lo;

  assign w_inc   = {1'b0, r_val} + {3'b000, r_s};
  assign w_inc_c = (w_inc > {1'b0, r_hi}) ? r_hi : w_inc[3:0];
  assign w_dec_c = ({1'b0, r_val} < ({1'b0, r_lo} + {3'b000, r_s})) ?
                   r_lo : (r_val - {2'b00, r_s});
  assign w_at_hi = (r_val == r_hi);
  assign w_at_lo = (r_val == r_lo);

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_up_nxt    = r_up;
    w_dcnt_nxt  = r_dcnt;
    w_err_nxt   = 1'b0;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_val_nxt = 4'd0;
        // stop dominates start; a conflicting request does nothing at all
        if (i_start && !i_stop) begin
          if (i_lo > i_hi) begin
            w_err_nxt = 1'b1;
          end else begin
            w_cap       = 1'b1;
            w_state_nxt = S_RUN;
            w_val_nxt   = i_lo;
            w_up_nxt    = 1'b1;
            w_dcnt_nxt  = i_dwell;
          end
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_val_nxt   = 4'd0;
        end else if (r_dcnt != '0) begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end else begin
          w_dcnt_nxt = r_dwell;
          case (r_mode)
            M_WRAP: w_val_nxt = w_at_hi ? r_lo : w_inc_c;
            M_BNC: begin
              if (r_up) begin
                if (w_at_hi) begin
                  w_up_nxt  = 1'b0;
                  w_val_nxt = w_dec_c;
                end else begin
                  w_val_nxt = w_inc_c;
                end
              end else begin
                if (w_at_lo) begin
                  w_up_nxt  = 1'b1;
                  w_val_nxt = w_inc_c;
                end else begin
                  w_val_nxt = w_dec_c;
                end
              end
            end
            default: begin
              // one-shot: hi has been shown for its full dwell, finish
              if (w_at_hi) w_state_nxt = S_DONE;
              else         w_val_nxt   = w_inc_c;
            end
          endcase
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_val_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_val_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_val   <= 4'd0;
      r_up    <= 1'b1;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
      r_lo    <= 4'd0;
      r_hi    <= 4'd0;
      r_s     <= 2'd1;
      r_mode  <= M_ONE;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_up    <= w_up_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_err   <= w_err_nxt;
      if (w_cap) begin
        r_lo    <= i_lo;
        r_hi    <= i_hi;
        r_s     <= (i_step == 2'd0) ? 2'd1 : i_step;
        r_mode  <= (i_mode == 2'b11) ? M_ONE : i_mode;
        r_dwell <= i_dwell;
      end
    end
  end

  // All outputs come straight from state flops.
  assign o_val  = r_val;
  assign o_en   = (r_state == S_RUN);
  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_err  = r_err;

endmodule

// File: tb/tb_nib_seq.sv
// Randomized self-checking bench for nib_seq. Expected per-cycle values come
// from a list-based model: the distinct values of a sweep are built as an
// up-path and a down-path, chained according to the mode, and each value is
// repeated dwell+1 times.
module tb_nib_seq;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst, start, stop;
  logic [3:0]         lo, hi;
  logic [1:0]         step, mode;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         val;
  logic               en, busy, done, err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  nib_seq #(.DWELL_W(DWELL_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_lo(lo), .i_hi(hi), .i_step(step), .i_mode(mode), .i_dwell(dwell),
    .o_val(val), .o_en(en), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // Observed word: {err, done, busy, en, val}
  function automatic logic [7:0] obs();
    return {err, done, busy, en, val};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s: got {err,done,busy,en,val}=%h expected %h at %0t", tag, o, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build the expected per-cycle val list (at most maxlen entries).
  task automatic build(input int l, input int h, input int st, input int md,
                       input int dw, input int maxlen);
    int s, m, v;
    int up_p[$], dn_p[$], dv[$];
    s = (st == 0) ? 1 : st;
    m = (md == 3) ? 0 : md;
    exp_q.delete();
    v = l; up_p.push_back(v);
    while (v != h) begin v = (v + s > h) ? h : v + s; up_p.push_back(v); end
    v = h; dn_p.push_back(v);
    while (v != l) begin v = (v - s < l) ? l : v - s; dn_p.push_back(v); end
    if (m == 0) dv = up_p;
    else if (m == 1) while (dv.size() < maxlen) foreach (up_p[i]) dv.push_back(up_p[i]);
    else if (l == h) while (dv.size() < maxlen) dv.push_back(l);
    else begin
      dv = up_p;
      while (dv.size() < maxlen) begin
        for (int i = 1; i < dn_p.size(); i++) dv.push_back(dn_p[i]);
        for (int i = 1; i < up_p.size(); i++) dv.push_back(up_p[i]);
      end
    end
    foreach (dv[i])
      for (int k = 0; k <= dw; k++)
        if (exp_q.size() < maxlen) exp_q.push_back(dv[i]);
  endtask

  // Launch one sequence and check every cycle. For wrap/bounce, stop is
  // raised while observing cycle stop_idx. With noisy set, start and the
  // config inputs toggle randomly while running and must be ignored.
  task automatic run_seq(input string tag, input int l, input int h, input int st,
                         input int md, input int dw, input int stop_idx, input bit noisy);
    bit one;
    int n;
    one = (md == 0 || md == 3);
    n = one ? 64 : stop_idx + 1;
    build(l, h, st, md, dw, n);
    lo = 4'(l); hi = 4'(h); step = 2'(st); mode = 2'(md); dwell = DWELL_W'(dw);
    start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_run"}, obs(), {4'b0011, 4'(exp_q[i])});
      if (noisy) begin
        start = 1'($urandom); lo = 4'($urandom); hi = 4'($urandom);
        step = 2'($urandom); mode = 2'($urandom); dwell = DWELL_W'($urandom);
      end
      if (!one && i == stop_idx) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    if (one) begin
      chk({tag, "_done"}, obs(), {4'b0110, 4'(h)});
      start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk({tag, "_idle"}, obs(), 8'h00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    lo = 0; hi = 0; step = 0; mode = 0; dwell = 0;
    tick(); tick();
    chk("reset", obs(), 8'h00);
    rst = 1'b0;
    tick();
    chk("idle", obs(), 8'h00);

    run_seq("oneshot", 3, 6, 0, 0, 0, 0, 1'b0);
    run_seq("clamp",   2, 11, 3, 0, 1, 0, 1'b0);
    run_seq("wrap",    8, 10, 1, 1, 0, 4, 1'b0);
    run_seq("bounce",  0, 4, 2, 2, 0, 9, 1'b0);
    run_seq("eq_one",  7, 7, 1, 3, 2, 0, 1'b0);
    run_seq("eq_bnc",  15, 15, 3, 2, 0, 5, 1'b0);
    run_seq("top",     13, 15, 3, 1, 0, 7, 1'b0);

    // Rejected start: single err pulse, stays idle.
    lo = 7; hi = 5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", obs(), 8'h80);
    tick();
    chk("err_clear", obs(), 8'h00);

    // start and stop together in IDLE: nothing happens (even with lo > hi).
    start = 1'b1; stop = 1'b1; lo = 2; hi = 9;
    tick();
    chk("conflict", obs(), 8'h00);
    lo = 9; hi = 2;
    tick();
    chk("conflict_err", obs(), 8'h00);
    start = 1'b0; stop = 1'b0;
    tick();

    // Reset mid-run in wrap mode, with start held during reset.
    lo = 1; hi = 5; step = 1; mode = 1; dwell = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    chk("rst_mid1", obs(), 8'h00);
    tick();
    chk("rst_mid2", obs(), 8'h00);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_after", obs(), 8'h00);
    run_seq("post_rst", 4, 9, 2, 0, 0, 0, 1'b0);

    // Randomized sequences with noisy inputs while running.
    for (int t = 0; t < 40; t++) begin
      int a, b;
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      if (a > b) begin int x; x = a; a = b; b = x; end
      run_seq("rnd", a, b, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 40), 1'b1);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
